decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, data/immediate width; the block SHALL support only XLEN=32 in this generation (other values rejected at elaboration).
REQ-002 Parameter NREGS, default 32, register-file entries (power of two, 2..32); register index width SHALL be RW=$clog2(NREGS).
REQ-003 Parameter BYPASS, default 1, enables writeback-to-read forwarding when 1.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1 / in_ready  out  1 / instr  in  32: fetch-side handshake and instruction word.
REQ-007 flush  in  1  discard held decoded instruction.
REQ-008 wb_en  in  1 / wb_addr  in  RW / wb_data  in  XLEN: register-file write port.
REQ-009 out_valid  out  1 / out_ready  in  1: execute-side handshake.
REQ-010 op  out  4 / regA, regB, regD  out  RW / dataA, dataB  out  XLEN / offset  out  XLEN / Wenable  out  1 / illegal  out  1: decoded bundle.

Function
REQ-011 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-012 in_ready SHALL be combinational: !out_valid || out_ready (single output stage, one-cycle latency, full throughput).
REQ-013 On input transfer, all bundle outputs SHALL be registered from instr at that edge; latency exactly 1 cycle.
REQ-014 Bundle outputs SHALL hold stable while out_valid && !out_ready.
REQ-015 op: ADD(0110011,f3=000,f7=0000000)=1, SUB(f7=0100000)=2, ADDI(0010011,000)=3, LW(0000011,010)=4, LB(0000011,000)=5, SW(0100011,010)=6, SB(0100011,000)=7, BEQ(1100011,000)=8, BNE(1100011,001)=9, LUI(0110111)=10, JAL(1101111)=11; any other encoding SHALL give op=0, illegal=1.
REQ-016 regA=instr[19:15], regB=instr[24:20], regD=instr[11:7], each truncated to RW bits; a field index >= NREGS SHALL set illegal=1, op=0.
REQ-017 offset: I-type (ADDI, loads) sign-extended instr[31:20]; S-type sign-extended {instr[31:25],instr[11:7]}; B-type sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; U-type {instr[31:12],12'b0}; J-type sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}; R-type and illegal 0.
REQ-018 Wenable SHALL be 1 for ops 1,2,3,4,5,10,11 with regD!=0, else 0.
REQ-019 Register file NREGS x XLEN; entry 0 SHALL read 0 always; writes with wb_addr=0 ignored.
REQ-020 wb_en write SHALL occur at the edge regardless of handshake state, including stall and flush cycles.
REQ-021 dataA/dataB SHALL be the register values for regA/regB at input transfer; when BYPASS=1 and wb_en && wb_addr==index && index!=0 in the same cycle, wb_data SHALL be used; when BYPASS=0, the pre-write value SHALL be used.
REQ-022 dataB SHALL read the register at regB for every op (stores/branches need it); consumers ignore it where unused.
REQ-023 flush SHALL clear out_valid at the next edge and take priority over a simultaneous input transfer (transferred instruction dropped); in_ready is unaffected by flush.
REQ-024 Simultaneous output and input transfer SHALL replace the bundle with the new instruction, out_valid remaining 1.

Reset
REQ-025 While reset=0 at an edge: out_valid=0, op=0, regA=regB=regD=0, dataA=dataB=offset=0, Wenable=0, illegal=0, all register entries 0.
REQ-026 wb_en and in_valid SHALL be ignored during reset; a held instruction SHALL be discarded by reset.

Verification
REQ-027 Reset, then all regs read 0; instr 0x00500093 (ADDI x1,x0,5) -> next cycle op=3, regD=1, offset=5, dataA=0, Wenable=1, out_valid=1.
REQ-028 wb x2=0x1234 same cycle as ADD x3,x2,x2 (0x002101B3), BYPASS=1 -> dataA=dataB=0x1234, op=1; BYPASS=0 -> both 0.
REQ-029 out_ready=0 for 3 cycles after SW (0x0020A223) -> in_ready=0, bundle stable, op=6, offset=4; out_ready=1 -> accepts next instruction same cycle.
REQ-030 BEQ offset -4 (0xFE000EE3) -> offset=0xFFFFFFFC, Wenable=0; JAL x1,+2048 (0x001000EF) -> op=11, offset=0x00000800.
REQ-031 flush with in_valid=1 -> out_valid=0 next cycle; opcode 0x0000007F -> illegal=1, op=0; ADD to x0 -> Wenable=0.
REQ-032 NREGS=16, ADD x17,x1,x2 -> illegal=1, op=0; wb to x0 then read x0 -> 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: a single registered output slot that holds one
// decoded RV32 subset instruction together with its source operands. The
// register file lives here, and a writeback port can forward into operand reads.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      op,
    output logic [RW-1:0]   regA,
    output logic [RW-1:0]   regB,
    output logic [RW-1:0]   regD,
    output logic [XLEN-1:0] dataA,
    output logic [XLEN-1:0] dataB,
    output logic [XLEN-1:0] offset,
    output logic            Wenable,
    output logic            illegal
);

    // Only the 32-bit datapath is implemented; other widths must not build.
    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("decode_stage: only XLEN=32 is supported");
        end
        if (NREGS < 2 || NREGS > 32 || (NREGS & (NREGS - 1)) != 0) begin : g_nregs_check
            $error("decode_stage: NREGS must be a power of two in 2..32");
        end
    endgenerate

    // Immediate layout selector for the offset field.
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_t;

    localparam logic [6:0] OPC_REG  = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_BRAN = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RW-1:0]   dec_ra;
    logic [RW-1:0]   dec_rb;
    logic [RW-1:0]   dec_rd;
    logic            field_bad;
    logic [3:0]      dec_op;
    fmt_t            dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_offset;
    logic            dec_wen;
    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;
    logic [XLEN-1:0] rf_q [NREGS];

    logic            valid_reg;
    logic [3:0]      op_reg;
    logic [RW-1:0]   rega_reg;
    logic [RW-1:0]   regb_reg;
    logic [RW-1:0]   regd_reg;
    logic [XLEN-1:0] dataa_reg;
    logic [XLEN-1:0] datab_reg;
    logic [XLEN-1:0] offset_reg;
    logic            wen_reg;
    logic            illegal_reg;

    logic            in_xfer;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign dec_ra = instr[15 +: RW];
    assign dec_rb = instr[20 +: RW];
    assign dec_rd = instr[7 +: RW];

    // Any of the three raw 5-bit register fields naming a missing register
    // makes the word illegal, whatever the instruction format.
    assign field_bad = ({27'd0, instr[19:15]} >= 32'(NREGS)) ||
                       ({27'd0, instr[24:20]} >= 32'(NREGS)) ||
                       ({27'd0, instr[11:7]}  >= 32'(NREGS));

    // Opcode/funct match to op code and immediate format; unmatched words are illegal.
    always_comb begin
        dec_op  = 4'd0;
        dec_fmt = FMT_R;
        case (opcode)
            OPC_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_op = 4'd1;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_op = 4'd2;
                end
            end
            OPC_IMM: begin
                dec_fmt = FMT_I;
                if (funct3 == 3'b000) dec_op = 4'd3;
            end
            OPC_LOAD: begin
                dec_fmt = FMT_I;
                if (funct3 == 3'b010)      dec_op = 4'd4;
                else if (funct3 == 3'b000) dec_op = 4'd5;
            end
            OPC_STOR: begin
                dec_fmt = FMT_S;
                if (funct3 == 3'b010)      dec_op = 4'd6;
                else if (funct3 == 3'b000) dec_op = 4'd7;
            end
            OPC_BRAN: begin
                dec_fmt = FMT_B;
                if (funct3 == 3'b000)      dec_op = 4'd8;
                else if (funct3 == 3'b001) dec_op = 4'd9;
            end
            OPC_LUI: begin
                dec_fmt = FMT_U;
                dec_op  = 4'd10;
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                dec_op  = 4'd11;
            end
            default: begin
                dec_op  = 4'd0;
                dec_fmt = FMT_R;
            end
        endcase
        dec_illegal = (dec_op == 4'd0) || field_bad;
        if (dec_illegal) begin
            dec_op  = 4'd0;
            dec_fmt = FMT_R;
        end
    end

    // Immediate extraction; R-type and illegal words carry a zero offset.
    always_comb begin
        dec_offset = '0;
        case (dec_fmt)
            FMT_I: dec_offset = {{20{instr[31]}}, instr[31:20]};
            FMT_S: dec_offset = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: dec_offset = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
            FMT_U: dec_offset = {instr[31:12], 12'b0};
            FMT_J: dec_offset = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
            default: dec_offset = '0;
        endcase
    end

    // Register-writing ops request writeback only when the destination is not x0.
    always_comb begin
        dec_wen = 1'b0;
        case (dec_op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd11: dec_wen = (dec_rd != '0);
            default: dec_wen = 1'b0;
        endcase
    end

    // Register file: entry 0 is hard-wired to zero, others are plain flops
    // so that reset can clear every entry in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_entry
                logic [XLEN-1:0] entry_reg;
                // Write this entry whenever writeback targets it, independent of handshakes.
                always_ff @(posedge clock) begin
                    if (!reset) begin
                        entry_reg <= '0;
                    end else if (wb_en && wb_addr == RW'(gi)) begin
                        entry_reg <= wb_data;
                    end
                end
                assign rf_q[gi] = entry_reg;
            end
        end
    endgenerate

    // Operand read with optional same-cycle forwarding from the writeback port.
    always_comb begin
        rd_a = rf_q[dec_ra];
        rd_b = rf_q[dec_rb];
        if (BYPASS != 0 && wb_en && wb_addr == dec_ra && dec_ra != '0) rd_a = wb_data;
        if (BYPASS != 0 && wb_en && wb_addr == dec_rb && dec_rb != '0) rd_b = wb_data;
    end

    assign in_ready = !valid_reg || out_ready;
    assign in_xfer  = in_valid && in_ready;

    // Output slot: flush beats a new load; a load replaces the bundle even
    // when the old one leaves in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_reg   <= 1'b0;
            op_reg      <= '0;
            rega_reg    <= '0;
            regb_reg    <= '0;
            regd_reg    <= '0;
            dataa_reg   <= '0;
            datab_reg   <= '0;
            offset_reg  <= '0;
            wen_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (in_xfer) begin
            valid_reg   <= 1'b1;
            op_reg      <= dec_op;
            rega_reg    <= dec_ra;
            regb_reg    <= dec_rb;
            regd_reg    <= dec_rd;
            dataa_reg   <= rd_a;
            datab_reg   <= rd_b;
            offset_reg  <= dec_offset;
            wen_reg     <= dec_wen;
            illegal_reg <= dec_illegal;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign op        = op_reg;
    assign regA      = rega_reg;
    assign regB      = regb_reg;
    assign regD      = regd_reg;
    assign dataA     = dataa_reg;
    assign dataB     = datab_reg;
    assign offset    = offset_reg;
    assign Wenable   = wen_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed checks of the documented scenarios, then
// random traffic compared against a behavioural model of the stage.
module tb_decode_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [31:0] da;
        logic [31:0] db;
        logic [31:0] off;
        logic        wen;
        logic        ill;
    } bundle_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_ready;

    // default instance
    logic        in_ready, out_valid, Wenable, illegal;
    logic [3:0]  op;
    logic [4:0]  regA, regB, regD;
    logic [31:0] dataA, dataB, offset;
    // no-bypass instance
    logic        in_ready_nb, out_valid_nb, Wenable_nb, illegal_nb;
    logic [3:0]  op_nb;
    logic [4:0]  regA_nb, regB_nb, regD_nb;
    logic [31:0] dataA_nb, dataB_nb, offset_nb;
    // 16-register instance
    logic        in_ready_16, out_valid_16, Wenable_16, illegal_16;
    logic [3:0]  op_16;
    logic [3:0]  regA_16, regB_16, regD_16;
    logic [31:0] dataA_16, dataB_16, offset_16;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic        m_valid;
    logic        m_zero;
    bundle_t     m_b;
    logic [31:0] m_nb_da, m_nb_db;
    logic [31:0] rf [32];

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .regA(regA), .regB(regB), .regD(regD), .dataA(dataA),
        .dataB(dataB), .offset(offset), .Wenable(Wenable), .illegal(illegal)
    );

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb),
        .instr(instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid_nb), .out_ready(out_ready),
        .op(op_nb), .regA(regA_nb), .regB(regB_nb), .regD(regD_nb), .dataA(dataA_nb),
        .dataB(dataB_nb), .offset(offset_nb), .Wenable(Wenable_nb), .illegal(illegal_nb)
    );

    decode_stage #(.XLEN(32), .NREGS(16), .BYPASS(1)) dut16 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_16),
        .instr(instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr[3:0]),
        .wb_data(wb_data), .out_valid(out_valid_16), .out_ready(out_ready),
        .op(op_16), .regA(regA_16), .regB(regB_16), .regD(regD_16), .dataA(dataA_16),
        .dataB(dataB_16), .offset(offset_16), .Wenable(Wenable_16), .illegal(illegal_16)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected decode of a word for a 32-entry register file, built from the
    // instruction-set rules with integer arithmetic.
    function automatic bundle_t ref_decode(input logic [31:0] w);
        bundle_t b;
        int s, opc, f3, f7, kind, v;
        b    = '0;
        s    = $signed(w);
        opc  = int'(w[6:0]);
        f3   = int'(w[14:12]);
        f7   = int'(w[31:25]);
        kind = 0;  // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
        if (opc == 'h33 && f3 == 0 && f7 == 0)          b.op = 4'd1;
        else if (opc == 'h33 && f3 == 0 && f7 == 'h20)  b.op = 4'd2;
        else if (opc == 'h13 && f3 == 0) begin b.op = 4'd3;  kind = 1; end
        else if (opc == 'h03 && f3 == 2) begin b.op = 4'd4;  kind = 1; end
        else if (opc == 'h03 && f3 == 0) begin b.op = 4'd5;  kind = 1; end
        else if (opc == 'h23 && f3 == 2) begin b.op = 4'd6;  kind = 2; end
        else if (opc == 'h23 && f3 == 0) begin b.op = 4'd7;  kind = 2; end
        else if (opc == 'h63 && f3 == 0) begin b.op = 4'd8;  kind = 3; end
        else if (opc == 'h63 && f3 == 1) begin b.op = 4'd9;  kind = 3; end
        else if (opc == 'h37)            begin b.op = 4'd10; kind = 4; end
        else if (opc == 'h6F)            begin b.op = 4'd11; kind = 5; end
        b.ra  = w[19:15];
        b.rb  = w[24:20];
        b.rd  = w[11:7];
        b.ill = (b.op == 4'd0);
        case (kind)
            1: v = s >>> 20;
            2: v = (s >>> 25) * 32 + int'(w[11:7]);
            3: v = (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            4: v = int'(w & 32'hFFFF_F000);
            5: v = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default: v = 0;
        endcase
        b.off = 32'(v);
        b.wen = (b.op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd11}) && (b.rd != 5'd0);
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
            1:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
            2:  begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
            3:  begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            4:  begin w[6:0] = 7'h03; w[14:12] = 3'd0; end
            5:  begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
            6:  begin w[6:0] = 7'h23; w[14:12] = 3'd0; end
            7:  begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
            8:  begin w[6:0] = 7'h63; w[14:12] = 3'd1; end
            9:  w[6:0] = 7'h37;
            10: w[6:0] = 7'h6F;
            11: w[11:7] = 5'd0;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: check in_ready, advance the model, then check the outputs.
    task automatic tick();
        bundle_t     d;
        logic        rdy;
        logic [31:0] va, vb;
        #1;
        rdy = !m_valid || out_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("in_ready_nb", 32'(in_ready_nb), 32'(rdy));
        chk("in_ready_16", 32'(in_ready_16), 32'(rdy));
        if (!reset) begin
            m_valid = 1'b0;
            m_zero  = 1'b1;
            m_b     = '0;
            m_nb_da = '0;
            m_nb_db = '0;
            for (int i = 0; i < 32; i++) rf[i] = '0;
        end else begin
            d  = ref_decode(instr);
            va = rf[d.ra];
            vb = rf[d.rb];
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && rdy) begin
                m_b     = d;
                m_b.da  = (wb_en && wb_addr == d.ra && d.ra != 5'd0) ? wb_data : va;
                m_b.db  = (wb_en && wb_addr == d.rb && d.rb != 5'd0) ? wb_data : vb;
                m_nb_da = va;
                m_nb_db = vb;
                m_valid = 1'b1;
                m_zero  = 1'b0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) rf[wb_addr] = wb_data;
        end
        @(posedge clock);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_valid_nb", 32'(out_valid_nb), 32'(m_valid));
        chk("out_valid_16", 32'(out_valid_16), 32'(m_valid));
        if (m_valid || m_zero) begin
            chk("op", 32'(op), 32'(m_b.op));
            chk("regA", 32'(regA), 32'(m_b.ra));
            chk("regB", 32'(regB), 32'(m_b.rb));
            chk("regD", 32'(regD), 32'(m_b.rd));
            chk("dataA", dataA, m_b.da);
            chk("dataB", dataB, m_b.db);
            chk("offset", offset, m_b.off);
            chk("Wenable", 32'(Wenable), 32'(m_b.wen));
            chk("illegal", 32'(illegal), 32'(m_b.ill));
            chk("op_nb", 32'(op_nb), 32'(m_b.op));
            chk("offset_nb", offset_nb, m_b.off);
            chk("dataA_nb", dataA_nb, m_nb_da);
            chk("dataB_nb", dataB_nb, m_nb_db);
        end
        $display("t=%0t rst=%b iv=%b instr=%h fl=%b wb=%b/%0d/%h or=%b -> ov=%b op=%0d dA=%h dB=%h off=%h",
                 $time, reset, in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
                 out_valid, op, dataA, dataB, offset);
    endtask

    initial begin
        clock     = 1'b0;
        m_valid   = 1'b0;
        m_zero    = 1'b0;
        m_b       = '0;
        m_nb_da   = '0;
        m_nb_db   = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // reset with writeback and input activity that must be ignored
        reset     = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h0050_0093;
        flush     = 1'b0;
        wb_en     = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_offset", offset, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_op_16", 32'(op_16), 32'd0);
        chk("rst_out_valid_16", 32'(out_valid_16), 32'd0);

        reset    = 1'b1;
        wb_en    = 1'b0;
        in_valid = 1'b0;
        tick();

        // every register reads zero after reset
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            instr    = {7'd0, 5'(31 - i), 5'(i), 3'd0, 5'd0, 7'h33};
            tick();
            chk("rst_rf_a", dataA, 32'd0);
            chk("rst_rf_b", dataB, 32'd0);
        end

        // ADDI x1,x0,5
        instr = 32'h0050_0093;
        tick();
        chk("addi_op", 32'(op), 32'd3);
        chk("addi_regD", 32'(regD), 32'd1);
        chk("addi_offset", offset, 32'd5);
        chk("addi_dataA", dataA, 32'd0);
        chk("addi_Wenable", 32'(Wenable), 32'd1);
        chk("addi_out_valid", 32'(out_valid), 32'd1);

        // writeback x2 in the same cycle as ADD x3,x2,x2
        wb_en   = 1'b1;
        wb_addr = 5'd2;
        wb_data = 32'h0000_1234;
        instr   = 32'h0021_01B3;
        tick();
        wb_en = 1'b0;
        chk("byp_op", 32'(op), 32'd1);
        chk("byp_dataA", dataA, 32'h1234);
        chk("byp_dataB", dataB, 32'h1234);
        chk("nobyp_dataA", dataA_nb, 32'd0);
        chk("nobyp_dataB", dataB_nb, 32'd0);

        // SW then a three-cycle stall with a new instruction waiting
        instr = 32'h0020_A223;
        tick();
        out_ready = 1'b0;
        instr     = 32'h0050_0093;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_op", 32'(op), 32'd6);
            chk("stall_offset", offset, 32'd4);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("release_op", 32'(op), 32'd3);

        // BEQ -4 and JAL +2048
        instr = 32'hFE00_0EE3;
        tick();
        chk("beq_op", 32'(op), 32'd8);
        chk("beq_offset", offset, 32'hFFFF_FFFC);
        chk("beq_Wenable", 32'(Wenable), 32'd0);
        instr = 32'h0010_00EF;
        tick();
        chk("jal_op", 32'(op), 32'd11);
        chk("jal_offset", offset, 32'h0000_0800);

        // flush wins over a simultaneous input transfer
        instr = 32'h0050_0093;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);

        // unknown opcode, then ADD to x0
        instr = 32'h0000_007F;
        tick();
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_op", 32'(op), 32'd0);
        instr = 32'h0020_8033;
        tick();
        chk("addx0_op", 32'(op), 32'd1);
        chk("addx0_Wenable", 32'(Wenable), 32'd0);

        // ADD x17,x1,x2 is out of range for 16 registers
        instr = 32'h0020_88B3;
        tick();
        chk("r16_illegal", 32'(illegal_16), 32'd1);
        chk("r16_op", 32'(op_16), 32'd0);
        chk("r16_Wenable", 32'(Wenable_16), 32'd0);
        chk("r16_out_valid", 32'(out_valid_16), 32'd1);
        chk("r32_op", 32'(op), 32'd1);

        // write to x0 is ignored, then read x0
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'hFFFF_FFFF;
        tick();
        wb_en    = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h0000_00B3;
        tick();
        chk("x0_dataA_16", dataA_16, 32'd0);
        chk("x0_dataB_16", dataB_16, 32'd0);
        chk("x0_dataA", dataA, 32'd0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom);
            wb_data   = $urandom;
            instr     = rand_instr();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
